wb_commit_stage: RTL and testbench

- Parametrised successor to the single-entry writeback stage.
- Sits after the memory stage and accepts one instruction per cycle over a valid/allowin handshake.
- Buffers up to DEPTH instructions and retires them in order to the register file. The register file may back-pressure through rf_ready.
- Drives an external CSR unit and raises exception/ertn flushes with a redirect target. The CSR file is no longer instantiated inside this stage.

---
 rtl/wb_commit_stage_pkg.sv | 11 +
 rtl/wb_commit_fifo.sv | 41 ++++
 rtl/wb_commit_stage.sv | 117 +++++++++++
 tb/tb_wb_commit_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_stage_pkg.sv
// wb_commit_stage_pkg: shared exception codes, field widths and FSM states for the commit stage.
package wb_commit_stage_pkg;
  localparam int ECODE_W = 6;
  localparam int ESUBCODE_W = 9;
  localparam int WS_TO_RF_BUS_W = 1 + 5 + 32;
  localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0B;
  typedef enum logic {RUN, FLUSH} ws_state_e;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/wb_commit_fifo.sv
// wb_commit_fifo: circular DEPTH-entry buffer with push, pop, flush and occupancy count.
module wb_commit_fifo
  import wb_commit_stage_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + PW'(1);
  endfunction
  assign head_data = mem[head];
  always_ff @(posedge clk)
    if (push) mem[tail] <= wdata;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= inc(tail);
      if (pop) head <= inc(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: in-order commit buffer retiring to the GPR file, driving CSR access and exception/ertn flush.
// Define WB_PERF_CNT_EN to add the 64-bit perf_retired counter.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int CSR_NUM_W = 14,
  parameter int DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ms_to_ws_valid,
  output logic                  ws_allowin,
  input  logic [DATA_W-1:0]     ms_pc,
  input  logic                  ms_gr_we,
  input  logic [RADDR_W-1:0]    ms_dest,
  input  logic [DATA_W-1:0]     ms_result,
  input  logic                  ms_csr_re,
  input  logic                  ms_csr_we,
  input  logic [CSR_NUM_W-1:0]  ms_csr_num,
  input  logic [DATA_W-1:0]     ms_csr_wmask,
  input  logic [DATA_W-1:0]     ms_csr_wvalue,
  input  logic                  ms_ex,
  input  logic [ECODE_W-1:0]    ms_ecode,
  input  logic [ESUBCODE_W-1:0] ms_esubcode,
  input  logic                  ms_ertn,
  input  logic                  rf_ready,
  output logic                  rf_we,
  output logic [RADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [CSR_NUM_W-1:0]  csr_num,
  input  logic [DATA_W-1:0]     csr_rvalue,
  output logic                  csr_we,
  output logic [DATA_W-1:0]     csr_wmask,
  output logic [DATA_W-1:0]     csr_wvalue,
  input  logic [DATA_W-1:0]     csr_eentry,
  input  logic [DATA_W-1:0]     csr_era,
  output logic                  wb_ex,
  output logic [ECODE_W-1:0]    wb_ecode,
  output logic [ESUBCODE_W-1:0] wb_esubcode,
  output logic [DATA_W-1:0]     wb_pc,
  output logic                  eret_flush,
  output logic                  ws_flush,
  output logic [DATA_W-1:0]     ws_flush_target,
  output logic [DATA_W-1:0]     debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [RADDR_W-1:0]    debug_wb_rf_wnum,
  output logic [DATA_W-1:0]     debug_wb_rf_wdata
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]           perf_retired
`endif
);
  localparam int EW = 4*DATA_W + RADDR_W + CSR_NUM_W + ECODE_W + ESUBCODE_W + 5;
  localparam int CW = $clog2(DEPTH+1);
  ws_state_e state, state_nxt;
  logic [EW-1:0] head_data;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] h_pc, h_result, h_wmask, h_wvalue;
  logic h_gr_we, h_csr_re, h_csr_we, h_ex, h_ertn;
  logic [RADDR_W-1:0] h_dest;
  logic [CSR_NUM_W-1:0] h_csr_num;
  logic [ECODE_W-1:0] h_ecode;
  logic [ESUBCODE_W-1:0] h_esub;
  logic head_valid, head_needs_rf, head_retire, flush, push;
  assign {h_pc, h_gr_we, h_dest, h_result, h_csr_re, h_csr_we, h_csr_num,
          h_wmask, h_wvalue, h_ex, h_ecode, h_esub, h_ertn} = head_data;
  assign head_valid    = count != '0;
  assign head_needs_rf = h_gr_we || h_csr_re;
  assign head_retire   = head_valid && (!head_needs_rf || rf_ready || h_ex || h_ertn);
  assign flush         = head_valid && (h_ex || h_ertn);
  // a push coinciding with a flush belongs to the squashed path and is dropped
  assign push          = ms_to_ws_valid && ws_allowin && !flush;
  wb_commit_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .pop       (head_retire),
    .flush     (flush),
    .wdata     ({ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_re, ms_csr_we, ms_csr_num,
                 ms_csr_wmask, ms_csr_wvalue, ms_ex, ms_ecode, ms_esubcode, ms_ertn}),
    .head_data (head_data),
    .count     (count)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= RUN;
    else state <= state_nxt;
  always_comb begin
    state_nxt  = (state == RUN && flush) ? FLUSH : RUN;
    ws_allowin = (state == RUN) && (count < CW'(DEPTH) || head_retire);
  end
  // head-derived data outputs read as zero while the buffer is empty
  assign rf_we             = head_valid && head_needs_rf && rf_ready && !h_ex && !h_ertn;
  assign rf_waddr          = head_valid ? h_dest : '0;
  assign rf_wdata          = !head_valid ? '0 : h_csr_re ? csr_rvalue : h_result;
  assign csr_num           = head_valid ? h_csr_num : '0;
  assign csr_we            = head_retire && h_csr_we && !h_ex;
  assign csr_wmask         = head_valid ? h_wmask : '0;
  assign csr_wvalue        = head_valid ? h_wvalue : '0;
  assign wb_ex             = head_valid && h_ex;
  assign wb_ecode          = head_valid ? h_ecode : '0;
  assign wb_esubcode       = head_valid ? h_esub : '0;
  assign wb_pc             = head_valid ? h_pc : '0;
  assign eret_flush        = head_valid && h_ertn && !h_ex;
  assign ws_flush          = flush;
  assign ws_flush_target   = wb_ex ? csr_eentry : eret_flush ? csr_era : '0;
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) perf_retired <= '0;
    else if (head_retire) perf_retired <= perf_retired + 64'd1;
`endif
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage: directed stimulus against a queue-based reference model compared every cycle.
module tb_wb_commit_stage;
  import wb_commit_stage_pkg::*;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        ertn;
  } ent_t;
  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, rf_ready = 1'b1;
  ent_t in_e = '0;
  logic [31:0] csr_rvalue = '0, csr_eentry = '0, csr_era = '0;
  logic ws_allowin, rf_we, csr_we, wb_ex, eret_flush, ws_flush;
  logic [4:0] rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, csr_wmask, csr_wvalue, wb_pc, ws_flush_target, debug_wb_pc, debug_wb_rf_wdata;
  logic [13:0] csr_num;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic [3:0] debug_wb_rf_wen;
  logic [63:0] m_ret = '0;
`ifdef WB_PERF_CNT_EN
  logic [63:0] perf_retired;
`endif
  int tests = 0, fails = 0;
  ent_t mq[$];
  logic m_fl = 1'b0;
  always #5 clk = ~clk;
  wb_commit_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(in_valid), .ws_allowin(ws_allowin),
    .ms_pc(in_e.pc), .ms_gr_we(in_e.gr_we), .ms_dest(in_e.dest), .ms_result(in_e.result),
    .ms_csr_re(in_e.csr_re), .ms_csr_we(in_e.csr_we), .ms_csr_num(in_e.csr_num),
    .ms_csr_wmask(in_e.wmask), .ms_csr_wvalue(in_e.wvalue), .ms_ex(in_e.ex),
    .ms_ecode(in_e.ecode), .ms_esubcode(in_e.esub), .ms_ertn(in_e.ertn),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .eret_flush(eret_flush), .ws_flush(ws_flush), .ws_flush_target(ws_flush_target),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_PERF_CNT_EN
    , .perf_retired(perf_retired)
`endif
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic m_retire();
    if (mq.size() == 0) return 1'b0;
    return !(mq[0].gr_we || mq[0].csr_re) || rf_ready || mq[0].ex || mq[0].ertn;
  endfunction
  function automatic logic m_allow();
    return !m_fl && (mq.size() < DEPTH || m_retire());
  endfunction
  always @(posedge clk or negedge resetn) begin
    logic acc;
    if (!resetn) begin
      mq.delete();
      m_fl = 1'b0;
      m_ret = '0;
    end else if (m_fl) m_fl = 1'b0;
    else if (mq.size() != 0 && (mq[0].ex || mq[0].ertn)) begin
      mq.delete();
      m_fl = 1'b1;
      m_ret++;
    end else begin
      acc = in_valid && m_allow();
      if (m_retire()) begin
        void'(mq.pop_front());
        m_ret++;
      end
      if (acc) mq.push_back(in_e);
    end
  end
  always @(negedge clk) begin
    logic hv, ex, er, we;
    ent_t h;
    hv = mq.size() != 0;
    h = hv ? mq[0] : '0;
    ex = hv && h.ex;
    er = hv && h.ertn && !h.ex;
    we = hv && (h.gr_we || h.csr_re) && rf_ready && !h.ex && !h.ertn;
    chk("ws_allowin", 64'(ws_allowin), 64'(m_allow()));
    chk("rf_we", 64'(rf_we), 64'(we));
    chk("debug_wb_rf_wen", 64'(debug_wb_rf_wen), 64'({4{we}}));
    chk("csr_we", 64'(csr_we), 64'(m_retire() && h.csr_we && !h.ex));
    chk("wb_ex", 64'(wb_ex), 64'(ex));
    chk("eret_flush", 64'(eret_flush), 64'(er));
    chk("ws_flush", 64'(ws_flush), 64'(ex || er));
    if (ex || er) chk("ws_flush_target", 64'(ws_flush_target), 64'(ex ? csr_eentry : csr_era));
    if (ex) chk("wb_ecode", 64'({wb_ecode, wb_esubcode}), 64'({h.ecode, h.esub}));
    if (hv || !resetn) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(h.dest));
      chk("rf_wdata", 64'(rf_wdata), 64'(!hv ? 32'h0 : h.csr_re ? csr_rvalue : h.result));
      chk("csr_num", 64'(csr_num), 64'(h.csr_num));
      chk("csr_wdata", {csr_wmask, csr_wvalue}, {h.wmask, h.wvalue});
      chk("wb_pc", 64'(wb_pc), 64'(h.pc));
      chk("debug_pc", 64'(debug_wb_pc), 64'(h.pc));
      chk("debug_wnum", 64'(debug_wb_rf_wnum), 64'(rf_waddr));
      chk("debug_wdata", 64'(debug_wb_rf_wdata), 64'(rf_wdata));
    end
`ifdef WB_PERF_CNT_EN
    chk("perf_retired", perf_retired, m_ret);
`endif
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic ent_t gpr(input logic [4:0] d, input logic [31:0] r, input logic [31:0] pc);
    ent_t e;
    e = '0;
    e.pc = pc;
    e.gr_we = 1'b1;
    e.dest = d;
    e.result = r;
    e.csr_num = 14'h20;
    return e;
  endfunction
  initial begin
    ent_t e;
    repeat (2) tick();
    chk("rst_allowin", 64'(ws_allowin), 64'd1);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_flush", 64'(ws_flush), 64'd0);
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_e = gpr(5'(i + 1), 32'h100 + i, 32'h1C00_0000 + 4 * i);
      tick();
      chk("t1_allowin", 64'(ws_allowin), 64'd1);
      chk("t1_rf_we", 64'(rf_we), 64'd1);
      chk("t1_waddr", 64'(rf_waddr), 64'(i + 1));
      chk("t1_wdata", 64'(rf_wdata), 64'(32'h100 + i));
    end
    in_valid = 1'b0;
    tick();
    rf_ready = 1'b0;
    in_valid = 1'b1;
    in_e = gpr(5'd10, 32'hA, 32'h1C00_0010);
    tick();
    chk("t2_allowin1", 64'(ws_allowin), 64'd1);
    in_e = gpr(5'd11, 32'hB, 32'h1C00_0014);
    tick();
    chk("t2_allowin_full", 64'(ws_allowin), 64'd0);
    chk("t2_stall_rf_we", 64'(rf_we), 64'd0);
    in_e = gpr(5'd12, 32'hC, 32'h1C00_0018);
    tick();
    chk("t2_still_full", 64'(ws_allowin), 64'd0);
    chk("t2_stall_head", 64'(rf_waddr), 64'd10);
    rf_ready = 1'b1;
    #1;
    chk("t2_drain_a", 64'({rf_we, rf_waddr}), 64'({1'b1, 5'd10}));
    chk("t2_reopen", 64'(ws_allowin), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("t2_drain_b", 64'({rf_we, rf_waddr}), 64'({1'b1, 5'd11}));
    tick();
    chk("t2_drain_c", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 5'd12, 32'hC}));
    tick();
    chk("t2_empty", 64'(rf_we), 64'd0);
    rf_ready = 1'b0;
    csr_eentry = 32'h1C00_8000;
    in_valid = 1'b1;
    in_e = gpr(5'd3, 32'h3, 32'h1C00_003C);
    tick();
    e = '0;
    e.pc = 32'h1C00_0040;
    e.ex = 1'b1;
    e.ecode = ECODE_SYS;
    e.esub = 9'h1;
    e.gr_we = 1'b1;
    e.dest = 5'd6;
    e.csr_we = 1'b1;
    in_e = e;
    tick();
    in_e = gpr(5'd4, 32'h4, 32'h1C00_0044);
    rf_ready = 1'b1;
    tick();
    chk("t3_wb_ex", 64'(wb_ex), 64'd1);
    chk("t3_ws_flush", 64'(ws_flush), 64'd1);
    chk("t3_target", 64'(ws_flush_target), 64'h1C00_8000);
    chk("t3_rf_we", 64'(rf_we), 64'd0);
    chk("t3_csr_we", 64'(csr_we), 64'd0);
    chk("t3_ecode", 64'(wb_ecode), 64'h0B);
    chk("t3_pc", 64'(wb_pc), 64'h1C00_0040);
    in_e = gpr(5'd5, 32'h5, 32'h1C00_0048);
    tick();
    chk("t3_flush_allowin", 64'(ws_allowin), 64'd0);
    chk("t3_young_dropped", 64'({rf_we, wb_ex, ws_flush}), 64'd0);
    tick();
    chk("t3_run_allowin", 64'(ws_allowin), 64'd1);
    chk("t3_ignored_push", 64'(rf_we), 64'd0);
    csr_era = 32'h1C00_0104;
    e = '0;
    e.pc = 32'h1C00_0200;
    e.ertn = 1'b1;
    in_e = e;
    tick();
    in_valid = 1'b0;
    chk("t4_eret_flush", 64'(eret_flush), 64'd1);
    chk("t4_ws_flush", 64'(ws_flush), 64'd1);
    chk("t4_target", 64'(ws_flush_target), 64'h1C00_0104);
    chk("t4_wb_ex", 64'(wb_ex), 64'd0);
    repeat (2) tick();
    csr_rvalue = 32'hDEAD_BEEF;
    e = '0;
    e.pc = 32'h1C00_0300;
    e.csr_re = 1'b1;
    e.gr_we = 1'b1;
    e.dest = 5'd7;
    e.csr_num = 14'h006;
    e.result = 32'h1234;
    in_valid = 1'b1;
    in_e = e;
    tick();
    chk("t5_rf_we", 64'(rf_we), 64'd1);
    chk("t5_waddr", 64'(rf_waddr), 64'd7);
    chk("t5_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    chk("t5_csr_num", 64'(csr_num), 64'h6);
    e = '0;
    e.pc = 32'h1C00_0304;
    e.csr_we = 1'b1;
    e.csr_num = 14'h00C;
    e.wmask = 32'hFFFF_0000;
    e.wvalue = 32'h1234_5678;
    in_e = e;
    tick();
    chk("t5_csr_we", 64'(csr_we), 64'd1);
    chk("t5_csr_w", 64'({csr_wmask, csr_wvalue}), 64'hFFFF_0000_1234_5678);
    chk("t5_csr_num_w", 64'(csr_num), 64'hC);
    e = '0;
    e.pc = 32'h1C00_0308;
    e.ex = 1'b1;
    e.ertn = 1'b1;
    e.ecode = 6'h08;
    in_e = e;
    tick();
    in_valid = 1'b0;
    chk("t5_ex_prio", 64'({wb_ex, eret_flush}), 64'({1'b1, 1'b0}));
    chk("t5_ex_prio_tgt", 64'(ws_flush_target), 64'h1C00_8000);
    repeat (2) tick();
    rf_ready = 1'b0;
    in_valid = 1'b1;
    in_e = gpr(5'd9, 32'h99, 32'h1C00_0400);
    tick();
    in_e = gpr(5'd8, 32'h88, 32'h1C00_0404);
    tick();
    in_valid = 1'b0;
    chk("t6_full", 64'(ws_allowin), 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_strobes", 64'({rf_we, csr_we, wb_ex, eret_flush, ws_flush, debug_wb_rf_wen}), 64'd0);
    chk("t6_rst_data", 64'({rf_waddr, csr_num, debug_wb_rf_wnum}), 64'd0);
    chk("t6_rst_pc", 64'({debug_wb_pc, rf_wdata}), 64'd0);
    tick();
    resetn = 1'b1;
    rf_ready = 1'b1;
    tick();
    chk("t6_allowin", 64'(ws_allowin), 64'd1);
    chk("t6_no_commit", 64'(rf_we), 64'd0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
